// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-fetch handshake between pc_sequencer and instruction memory
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle fetch/execute/update PC sequencer; sole writer of the PC register
// Optional branch-alignment trap enabled by defining PC_SEQ_ALIGN_CHECK_EN (adds the misalign output).
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned PC_INC    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_cur,
    output logic                  pc_load,
    output logic [31:0]           pc_next,
    pc_sequencer_if.master        imem,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    input  logic                  stall,
    input  logic                  exec_done,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic                  trap,
    input  logic                  halt_req,
    output logic                  halted,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic                  misalign,
`endif
    output logic [31:0]           retired
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;
    logic        trap_eff;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
    logic        mis_pend_q, mis_pend_d;
    logic        bad_target;

    assign bad_target = branch_taken && (branch_target[1:0] != 2'b00) && !trap;
    assign trap_eff   = trap || bad_target;
`else
    assign trap_eff   = trap;
`endif

    always_comb begin
        state_d       = state_q;
        pc_load_d     = 1'b0;
        pc_next_d     = pc_next_q;
        req_d         = req_q;
        addr_d        = addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        halted_d      = halted_q;
        retired_d     = retired_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        misalign_d    = 1'b0;
        mis_pend_d    = mis_pend_q;
`endif
        case (state_q)
            S_BOOT: begin
                pc_load_d = 1'b1;
                pc_next_d = RESET_VEC;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                // pc_cur is stale while a load pulse is still in flight
                if (req_q) begin
                    if (imem.imem_ack) begin
                        instr_d       = imem.imem_rdata;
                        instr_pc_d    = addr_q;
                        req_d         = 1'b0;
                        instr_valid_d = 1'b1;
                        state_d       = S_EXEC;
                    end
                end else if (!stall && !pc_load_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_cur;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    retired_d     = retired_q + 32'd1;
                    instr_valid_d = 1'b0;
                    if (halt_req && !trap_eff) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        state_d = S_UPDATE;
                        if (trap_eff)
                            pc_next_d = TRAP_VEC;
                        else if (branch_taken)
                            pc_next_d = branch_target;
                        else
                            pc_next_d = instr_pc_q + 32'(PC_INC);
`ifdef PC_SEQ_ALIGN_CHECK_EN
                        mis_pend_d = bad_target;
`endif
                    end
                end
            end
            S_UPDATE: begin
                if (!stall) begin
                    pc_load_d = 1'b1;
                    state_d   = S_FETCH;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    misalign_d = mis_pend_q;
                    mis_pend_d = 1'b0;
`endif
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_load_q     <= 1'b0;
            pc_next_q     <= RESET_VEC;
            req_q         <= 1'b0;
            addr_q        <= 32'h0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            halted_q      <= 1'b0;
            retired_q     <= 32'h0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
            mis_pend_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_load_q     <= pc_load_d;
            pc_next_q     <= pc_next_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
            retired_q     <= retired_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_q    <= misalign_d;
            mis_pend_q    <= mis_pend_d;
`endif
        end
    end

    assign pc_load        = pc_load_q;
    assign pc_next        = pc_next_q;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign halted         = halted_q;
    assign retired        = retired_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign misalign       = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        halt_req;
    logic        halted;
    logic [31:0] retired;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_sequencer_if imem_if ();

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur        (pc_cur),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .imem          (imem_if),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .stall         (stall),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap          (trap),
        .halt_req      (halt_req),
        .halted        (halted),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .retired       (retired)
    );

`ifndef PC_SEQ_ALIGN_CHECK_EN
    assign misalign = 1'b0;
`endif

    always #5 clk = ~clk;

    // PC register model; non-zero reset value proves BOOT really loads RESET_VEC
    always @(posedge clk) begin
        if (rst)
            pc_cur <= 32'h0000_0FF0;
        else if (pc_load)
            pc_cur <= pc_next;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_if.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_timeout"}, {31'd0, imem_if.imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int delay,
                         input bit stall_pulse, input string tag);
        wait_req(tag);
        check({tag, "_addr"}, imem_if.imem_addr, a);
        check({tag, "_no_load_with_req"}, {31'd0, pc_load}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            if (stall_pulse && i == 0) stall = 1'b1;
            if (stall_pulse && i == 1) stall = 1'b0;
            @(negedge clk);
            check({tag, "_req_held"}, {31'd0, imem_if.imem_req}, 32'd1);
            check({tag, "_addr_held"}, imem_if.imem_addr, a);
        end
        stall = 1'b0;
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = d;
        @(negedge clk);
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr, d);
        check({tag, "_instr_pc"}, instr_pc, a);
    endtask

    task automatic execute(input bit br, input logic [31:0] tgt, input bit tp, input bit hr,
                           input logic [31:0] exp_ret, input bit exp_halt, input string tag);
        exec_done     = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        trap          = tp;
        halt_req      = hr;
        @(negedge clk);
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        trap          = 1'b0;
        halt_req      = 1'b0;
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_halted"}, {31'd0, halted}, {31'd0, exp_halt});
        check({tag, "_valid_low"}, {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic update(input int stall_cycles, input logic [31:0] exp_next, input string tag);
        check({tag, "_load_idle"}, {31'd0, pc_load}, 32'd0);
        if (stall_cycles > 0) stall = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            @(negedge clk);
            check({tag, "_load_stalled"}, {31'd0, pc_load}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check({tag, "_load"}, {31'd0, pc_load}, 32'd1);
        check({tag, "_pc_next"}, pc_next, exp_next);
    endtask

    initial begin
        logic [31:0] after_mis;
        rst                = 1'b1;
        stall              = 1'b0;
        exec_done          = 1'b0;
        branch_taken       = 1'b0;
        branch_target      = 32'h0;
        trap               = 1'b0;
        halt_req           = 1'b0;
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("rst_addr", imem_if.imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", retired, 32'h0);

        rst = 1'b0;
        @(negedge clk);
        check("boot_load", {31'd0, pc_load}, 32'd1);
        check("boot_pc_next", pc_next, 32'h0);
        check("boot_no_req", {31'd0, imem_if.imem_req}, 32'd0);

        fetch(32'h0, 32'hA000_0001, 0, 1'b0, "f0");
        @(negedge clk);
        check("e0_wait_valid", {31'd0, instr_valid}, 32'd1);
        check("e0_wait_retired", retired, 32'h0);
        execute(1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 1'b0, "e0");
        update(0, 32'h4, "u0");
        @(negedge clk);
        check("u0_single_pulse", {31'd0, pc_load}, 32'd0);

        fetch(32'h4, 32'hA000_0002, 0, 1'b0, "f1");
        execute(1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 1'b0, "e1");
        update(0, 32'h8, "u1");

        fetch(32'h8, 32'hA000_0003, 0, 1'b0, "f2");
        execute(1'b1, 32'h40, 1'b0, 1'b0, 32'd3, 1'b0, "br");
        update(0, 32'h40, "u_br");

        fetch(32'h40, 32'hA000_0004, 0, 1'b0, "f3");
        execute(1'b1, 32'h40, 1'b1, 1'b0, 32'd4, 1'b0, "trap_br");
        update(0, 32'h100, "u_trap_br");

        fetch(32'h100, 32'hA000_0005, 3, 1'b1, "f_hs");
        execute(1'b0, 32'h0, 1'b1, 1'b1, 32'd5, 1'b0, "trap_halt");
        update(2, 32'h100, "u_trap_halt");

        fetch(32'h100, 32'hA000_0006, 0, 1'b0, "f4");
        execute(1'b1, 32'h42, 1'b0, 1'b0, 32'd6, 1'b0, "mis");
`ifdef PC_SEQ_ALIGN_CHECK_EN
        update(0, 32'h100, "u_mis");
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        @(negedge clk);
        check("mis_clear", {31'd0, misalign}, 32'd0);
        after_mis = 32'h100;
`else
        update(0, 32'h42, "u_mis");
        after_mis = 32'h42;
`endif

        fetch(after_mis, 32'hA000_0007, 0, 1'b0, "f5");
        execute(1'b1, 32'hC, 1'b0, 1'b0, 32'd7, 1'b0, "br_c");
        update(0, 32'hC, "u_br_c");

        fetch(32'hC, 32'hA000_0008, 0, 1'b0, "f6");
        execute(1'b0, 32'h0, 1'b0, 1'b1, 32'd8, 1'b1, "halt");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) exec_done = 1'b1;
            if (i == 6) exec_done = 1'b0;
            @(negedge clk);
            check("halt_no_load", {31'd0, pc_load}, 32'd0);
            check("halt_no_req", {31'd0, imem_if.imem_req}, 32'd0);
        end
        check("halt_retired_frozen", retired, 32'd8);
        check("halt_still", {31'd0, halted}, 32'd1);

        rst = 1'b1;
        @(negedge clk);
        check("rst2_retired", retired, 32'h0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_instr", instr, 32'h0);
        check("rst2_instr_pc", instr_pc, 32'h0);
        check("rst2_pc_next", pc_next, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("boot2_load", {31'd0, pc_load}, 32'd1);
        wait_req("boot2");
        rst                = 1'b1;
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rst3_valid", {31'd0, instr_valid}, 32'd0);
        check("rst3_instr", instr, 32'h0);
        check("rst3_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("rst3_addr", imem_if.imem_addr, 32'h0);
        check("rst3_pc_load", {31'd0, pc_load}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
        check("boot3_load", {31'd0, pc_load}, 32'd1);
        check("boot3_pc_next", pc_next, 32'h0);
        check("boot3_valid", {31'd0, instr_valid}, 32'd0);
        check("boot3_instr", instr, 32'h0);

        fetch(32'h0, 32'hA000_0009, 0, 1'b0, "f7");
        execute(1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 1'b0, "e7");
        update(0, 32'h4, "u7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
